dsm_input_stage: RTL

Front end of the delta-sigma modulator loop, sitting directly upstream of the integrator. It accepts input words over a valid/ready handshake and holds each word for OSR modulator samples (zero-order hold). It generates the modulator sample strobe from the system clock and, on each strobe, presents the difference between the held input and the quantizer feedback level. Its `o_sample`/`o_data` pair drives the integrator's `i_sample`/`i_data` directly.

---
 rtl/dsm_input_stage.sv | 137 +++++++++++++
 1 files changed

// File: rtl/dsm_input_stage.sv
// Delta-sigma modulator input stage: valid/ready word intake, zero-order hold
// over OSR modulator samples, sample-strobe generation and feedback subtraction.
module dsm_input_stage #(
    parameter int unsigned DATA_WIDTH = 6,
    parameter int unsigned CLK_DIV    = 4,
    parameter int unsigned OSR        = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_in_valid,
    output logic                  o_in_ready,
    input  logic [DATA_WIDTH-3:0] i_in_data,
    input  logic                  i_fb_bit,
    output logic                  o_sample,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_underrun
);

    localparam int unsigned IN_W  = DATA_WIDTH - 2;
    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned OSR_W = (OSR > 1) ? $clog2(OSR) : 1;

    localparam logic [DATA_WIDTH-1:0] FB_LEVEL = DATA_WIDTH'(1) << (DATA_WIDTH - 3);
    localparam logic [DIV_W-1:0]      DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [OSR_W-1:0]      OSR_LAST = OSR_W'(OSR - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [IN_W-1:0]       next_q, next_d;
    logic                  next_valid_q, next_valid_d;
    logic [IN_W-1:0]       hold_q, hold_d;
    logic [DIV_W-1:0]      div_cnt_q, div_cnt_d;
    logic [OSR_W-1:0]      osr_cnt_q, osr_cnt_d;
    logic                  sample_q, sample_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  underrun_q, underrun_d;

    logic                  accept_c;
    logic                  tick_c;
    logic                  block_end_c;
    logic [DATA_WIDTH-1:0] hold_ext_c;

    // Buffer is free whenever no word is waiting
    assign o_in_ready = !next_valid_q;

    assign o_sample   = sample_q;
    assign o_data     = data_q;
    assign o_underrun = underrun_q;

    // Next-state logic: intake, tick/block sequencing and difference computation
    always_comb begin
        state_d      = state_q;
        next_d       = next_q;
        next_valid_d = next_valid_q;
        hold_d       = hold_q;
        div_cnt_d    = div_cnt_q;
        osr_cnt_d    = osr_cnt_q;
        sample_d     = 1'b0;
        data_d       = data_q;
        underrun_d   = 1'b0;

        accept_c    = i_in_valid && !next_valid_q;
        tick_c      = (state_q == S_RUN) && (div_cnt_q == DIV_LAST);
        block_end_c = tick_c && (osr_cnt_q == OSR_LAST);
        hold_ext_c  = {{2{hold_q[IN_W-1]}}, hold_q};

        // A word arriving on a block-end tick lands in the buffer only,
        // so it is picked up at the following block end.
        if (accept_c) begin
            next_d       = i_in_data;
            next_valid_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                div_cnt_d = '0;
                osr_cnt_d = '0;
                if (next_valid_q) begin
                    hold_d       = next_q;
                    next_valid_d = 1'b0;
                    state_d      = S_RUN;
                end
            end
            S_RUN: begin
                if (tick_c) begin
                    div_cnt_d = '0;
                    sample_d  = 1'b1;
                    data_d    = i_fb_bit ? (hold_ext_c - FB_LEVEL) : (hold_ext_c + FB_LEVEL);
                    if (block_end_c) begin
                        osr_cnt_d = '0;
                        if (next_valid_q) begin
                            hold_d       = next_q;
                            next_valid_d = 1'b0;
                        end else begin
                            underrun_d = 1'b1;
                        end
                    end else begin
                        osr_cnt_d = osr_cnt_q + OSR_W'(1);
                    end
                end else begin
                    div_cnt_d = div_cnt_q + DIV_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= S_IDLE;
            next_q       <= '0;
            next_valid_q <= 1'b0;
            hold_q       <= '0;
            div_cnt_q    <= '0;
            osr_cnt_q    <= '0;
            sample_q     <= 1'b0;
            data_q       <= '0;
            underrun_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            next_q       <= next_d;
            next_valid_q <= next_valid_d;
            hold_q       <= hold_d;
            div_cnt_q    <= div_cnt_d;
            osr_cnt_q    <= osr_cnt_d;
            sample_q     <= sample_d;
            data_q       <= data_d;
            underrun_q   <= underrun_d;
        end
    end

endmodule
